jpegls_run_decoder: RTL and testbench
=====================================

Name: jpegls_run_decoder

Overview:
Decoder-side counterpart of the encoder's run-mode coding path. It consumes the run-mode bitstream one bit per cycle from the bit reader and reconstructs the run length and the run-interruption decision using the JPEG-LS J table and RUNindex adaptation (T.87 A.7.1.2). It sits between the decoder bit reader and the pixel reconstruction stage, which replicates Ra for run_length pixels and then decodes the interruption sample.

Parameters:
runcount_length, 16, width of run_length and line_remaining
runindex_length, 5, width of RUNindex (0..31)
J_length, 4, width of J[RUNindex] (0..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
scan_start  input  1  pulse; clears RUNindex to 0 (ignored unless IDLE)
start  input  1  pulse; begin a run (accepted only in IDLE)
line_remaining  input  runcount_length  pixels left in the line including the current one; sampled on start
bit_in  input  1  next stream bit, MSB-first
bit_valid  input  1  bit_in valid
bit_ready  output  1  block consumes bit_in this cycle if bit_valid
busy  output  1  high in any state other than IDLE
run_done  output  1  one-cycle pulse; result outputs valid
run_length  output  runcount_length  decoded run length
run_interrupted  output  1  1 = run ended by a 0 bit, so an interruption sample follows; 0 = ended at EOL
run_index_o  output  runindex_length  RUNindex used for the interruption sample (pre-decrement)
run_error  output  1  remainder overran the line; qualified by run_done

Behaviour:
- Reset: state IDLE, RUNindex=0, all outputs 0. Reset mid-run abandons the run with no run_done.
- J table is fixed ROM: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15. rg=1<<J[RUNindex].
- Handshake: bit_ready=1 only in HITS and REMAINDER. A bit is consumed when bit_valid&&bit_ready. Cycles without a consumed bit change nothing.
- IDLE: scan_start clears RUNindex. If scan_start and start arrive together, the clear applies first. On start: latch rem=line_remaining and set cnt=0. Go to HITS next cycle. If line_remaining==0, go to DONE instead with length 0, interrupted 0, and no bits consumed.
- HITS, on consumed bit 1:
  - add=min(rg, rem-cnt); cnt+=add.
  - If add==rg and RUNindex<31, RUNindex++.
  - If cnt==rem, go to DONE with interrupted=0.
- HITS, on consumed bit 0: set interrupted=1 and latch idx=RUNindex.
  - If J[RUNindex]==0, go to DONE.
  - Otherwise go to REMAINDER and load the bit counter with J.
- REMAINDER: shift J bits MSB-first into rmd (15 bits max); after the last bit go to DONE.
- Entering DONE after an interruption: len=cnt+rmd, computed at runcount_length+1 bits.
  - If len>rem-1, set run_error=1 and clamp len to rem-1. The interruption pixel must fit.
  - If RUNindex>0, decrement RUNindex in the same cycle as run_done.
- DONE: assert run_done for 1 cycle with run_length, run_interrupted, run_index_o and run_error stable. Return to IDLE. Outputs hold their values until the next run_done; only the run_done pulse clears.
- Latency: start→HITS 1 cycle; last relevant bit→run_done next cycle; run_done→IDLE next cycle. A new start is accepted the cycle after run_done.
- start or scan_start while busy is ignored.
- Arithmetic: cnt saturates at rem by construction; no wrap-around.

Test Plan:
1. reset; scan_start; start rem=100; bit 0 -> run_done, run_length=0, interrupted=1, run_index_o=0; RUNindex stays 0.
2. rem=100, RUNindex=0; bits 1,1,1,1,0, then 1 remainder bit =1 (J[4]=1) -> run_length=5, interrupted=1, run_index_o=4; RUNindex becomes 3.
3. scan_start; rem=3; bits 1,1,1 -> run_length=3, interrupted=0, RUNindex=3; 4th bit_valid is not consumed (bit_ready=0 after DONE).
4. Following 3 (RUNindex=3, rg=1): rem=1; bit 1 -> cnt==rg so RUNindex=4, EOL, run_length=1. Then rem=1, RUNindex=4 (rg=2); bit 1 -> add=1≠rg, RUNindex stays 4, run_length=1, interrupted=0.
5. RUNindex=8 (J=2), rem=2: bit 0, bits 1,1 -> rmd=3>1 -> run_error=1, run_length=1, run_index_o=8, RUNindex=7.
6. bit_valid toggled 1-of-3 cycles and start pulsed while busy -> same results as scan 2, start ignored. Reset asserted in REMAINDER -> IDLE, RUNindex=0, no run_done.

Source files
------------

// File: rtl/jpegls_run_decoder_if.sv
// Run-decoder control and bitstream bundle: the bit reader handshake, run start/scan controls and the per-run result.
// master drives the stream and controls; slave is the decoder.
interface jpegls_run_decoder_if #(
    parameter int runcount_length = 16,
    parameter int runindex_length = 5
);
    logic                       scan_start;
    logic                       start;
    logic [runcount_length-1:0] line_remaining;
    logic                       bit_in;
    logic                       bit_valid;
    logic                       bit_ready;
    logic                       busy;
    logic                       run_done;
    logic [runcount_length-1:0] run_length;
    logic                       run_interrupted;
    logic [runindex_length-1:0] run_index_o;
    logic                       run_error;

    modport master (
        output scan_start, start, line_remaining, bit_in, bit_valid,
        input  bit_ready, busy, run_done, run_length, run_interrupted, run_index_o, run_error
    );

    modport slave (
        input  scan_start, start, line_remaining, bit_in, bit_valid,
        output bit_ready, busy, run_done, run_length, run_interrupted, run_index_o, run_error
    );
endinterface

// File: rtl/jpegls_run_decoder.sv
// JPEG-LS run-mode decoder: rebuilds run length and interruption flag from one stream bit per cycle with RUNindex adaptation.
// Latency: last relevant bit -> run_done next cycle; bits are taken only in HITS/REMAINDER, idle bit cycles change nothing.
module jpegls_run_decoder #(
    parameter int runcount_length = 16,
    parameter int runindex_length = 5,
    parameter int J_length        = 4
) (
    input logic                clk,
    input logic                reset,
    jpegls_run_decoder_if.slave io
);
    localparam int RMD_W = (1 << J_length) - 1;
    localparam logic [runcount_length-1:0] CONE = 1;
    localparam logic [runindex_length-1:0] XONE = 1;
    localparam logic [J_length-1:0]        JONE = 1;
    localparam logic [J_length-1:0] J_ROM [32] = '{
        0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3,
        4, 4, 5, 5, 6, 6, 7, 7, 8, 9, 10, 11, 12, 13, 14, 15
    };

    typedef enum logic [1:0] {IDLE, HITS, REMAINDER, DONE} state_t;

    state_t                     state;
    logic [runindex_length-1:0] run_index;
    logic [runcount_length-1:0] rem;
    logic [runcount_length-1:0] cnt;
    logic [RMD_W-1:0]           rmd;
    logic [J_length-1:0]        bit_cnt;

    logic [J_length-1:0]        j_cur;
    logic [runcount_length-1:0] rg, span, add, cnt_next, rem_m1, len_out;
    logic [RMD_W-1:0]           rmd_shift, rmd_in;
    logic [runcount_length:0]   len_sum;
    logic                       len_err, consume, finish_eol, finish_int;

    assign io.bit_ready = (state == HITS) || (state == REMAINDER);
    assign io.busy      = (state != IDLE);
    assign consume      = io.bit_valid && io.bit_ready;

    assign j_cur     = J_ROM[run_index];
    assign rg        = CONE << j_cur;
    assign span      = rem - cnt;
    assign add       = (rg < span) ? rg : span;
    assign cnt_next  = cnt + add;
    assign rmd_shift = {rmd[RMD_W-2:0], io.bit_in};
    assign rmd_in    = (state == REMAINDER) ? rmd_shift : '0;

    // Widened sum; the clamp keeps room for the interruption pixel itself.
    assign len_sum = {1'b0, cnt} + {{(runcount_length + 1 - RMD_W){1'b0}}, rmd_in};
    assign rem_m1  = rem - CONE;
    assign len_err = len_sum > {1'b0, rem_m1};
    assign len_out = len_err ? rem_m1 : len_sum[runcount_length-1:0];

    assign finish_eol = consume && (state == HITS) && io.bit_in && (cnt_next == rem);
    assign finish_int = consume && (((state == HITS) && !io.bit_in && (j_cur == '0)) ||
                                    ((state == REMAINDER) && (bit_cnt == JONE)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            run_index          <= '0;
            rem                <= '0;
            cnt                <= '0;
            rmd                <= '0;
            bit_cnt            <= '0;
            io.run_done        <= 1'b0;
            io.run_length      <= '0;
            io.run_interrupted <= 1'b0;
            io.run_index_o     <= '0;
            io.run_error       <= 1'b0;
        end else begin
            io.run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.scan_start) run_index <= '0;
                    if (io.start) begin
                        rem <= io.line_remaining;
                        cnt <= '0;
                        rmd <= '0;
                        if (io.line_remaining == '0) begin
                            state              <= DONE;
                            io.run_done        <= 1'b1;
                            io.run_length      <= '0;
                            io.run_interrupted <= 1'b0;
                            io.run_error       <= 1'b0;
                            io.run_index_o     <= io.scan_start ? '0 : run_index;
                        end else begin
                            state <= HITS;
                        end
                    end
                end
                HITS: begin
                    if (consume) begin
                        if (io.bit_in) begin
                            cnt <= cnt_next;
                            if ((add == rg) && (run_index != '1)) run_index <= run_index + XONE;
                        end else if (j_cur != '0) begin
                            state   <= REMAINDER;
                            bit_cnt <= j_cur;
                        end
                    end
                end
                REMAINDER: begin
                    if (consume) begin
                        rmd     <= rmd_shift;
                        bit_cnt <= bit_cnt - JONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (finish_eol) begin
                state              <= DONE;
                io.run_done        <= 1'b1;
                io.run_length      <= cnt_next;
                io.run_interrupted <= 1'b0;
                io.run_error       <= 1'b0;
                io.run_index_o     <= run_index;
            end

            // RUNindex is frozen during REMAINDER, so it still holds the pre-decrement value here.
            if (finish_int) begin
                state              <= DONE;
                io.run_done        <= 1'b1;
                io.run_length      <= len_out;
                io.run_interrupted <= 1'b1;
                io.run_error       <= len_err;
                io.run_index_o     <= run_index;
                if (run_index != '0) run_index <= run_index - XONE;
            end
        end
    end
endmodule

// File: tb/tb_jpegls_run_decoder.sv
// Scoreboard bench for jpegls_run_decoder: expected run results are queued when a run is launched and compared on run_done.
module tb_jpegls_run_decoder;
    localparam int RL = 16;
    localparam int XL = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jpegls_run_decoder_if #(.runcount_length(RL), .runindex_length(XL)) dif ();

    jpegls_run_decoder #(.runcount_length(RL), .runindex_length(XL), .J_length(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (dif)
    );

    typedef struct {
        int len;
        int intr;
        int idx;
        int err;
        bit chk_idx;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && dif.run_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_run_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("run_length", int'(dif.run_length), e.len);
                check("run_interrupted", int'(dif.run_interrupted), e.intr);
                check("run_error", int'(dif.run_error), e.err);
                if (e.chk_idx) check("run_index_o", int'(dif.run_index_o), e.idx);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int r, input bit scan);
        dif.scan_start     = scan;
        dif.start          = 1'b1;
        dif.line_remaining = 16'(r);
        @(negedge clk);
        dif.start      = 1'b0;
        dif.scan_start = 1'b0;
    endtask

    task automatic send_bit(input bit b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        dif.bit_in    = b;
        dif.bit_valid = 1'b1;
        t = 0;
        while (!dif.bit_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("bit_ready_timeout", 0, 1);
        @(negedge clk);
        dif.bit_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < target) check("run_done_timeout", done_cnt, target);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset              = 1'b1;
        dif.scan_start     = 1'b0;
        dif.start          = 1'b0;
        dif.line_remaining = '0;
        dif.bit_in         = 1'b0;
        dif.bit_valid      = 1'b0;
        tick(3);
        check("rst_busy", int'(dif.busy), 0);
        check("rst_bit_ready", int'(dif.bit_ready), 0);
        check("rst_run_done", int'(dif.run_done), 0);
        check("rst_run_length", int'(dif.run_length), 0);
        check("rst_run_index_o", int'(dif.run_index_o), 0);
        reset = 1'b0;
        tick(1);

        // Immediate interruption at RUNindex 0
        sb.push_back('{0, 1, 0, 0, 1'b1});
        do_start(100, 1'b1);
        send_bit(1'b0, 0);
        wait_done(1);

        // Four hits, interruption, one remainder bit
        sb.push_back('{5, 1, 4, 0, 1'b1});
        do_start(100, 1'b0);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0);
        wait_done(2);

        // End of line after three hits; extra bit must not be taken
        sb.push_back('{3, 0, 0, 0, 1'b0});
        do_start(3, 1'b1);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        dif.bit_valid = 1'b1;
        check("done_bit_ready", int'(dif.bit_ready), 0);
        tick(1);
        check("post_done_bit_ready", int'(dif.bit_ready), 0);
        check("run_done_width", int'(dif.run_done), 0);
        check("post_done_busy", int'(dif.busy), 0);
        dif.bit_valid = 1'b0;
        wait_done(3);

        // Full-rg EOL raises RUNindex 3->4; partial add leaves it at 4
        sb.push_back('{1, 0, 0, 0, 1'b0});
        do_start(1, 1'b0);
        send_bit(1'b1, 0);
        wait_done(4);
        sb.push_back('{1, 0, 0, 0, 1'b0});
        do_start(1, 1'b0);
        send_bit(1'b1, 0);
        wait_done(5);

        // Walk RUNindex 4->8 with full hits, then overrun the line
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{2, 0, 0, 0, 1'b0});
            do_start(2, 1'b0);
            send_bit(1'b1, 0);
            wait_done(6 + i);
        end
        sb.push_back('{1, 1, 8, 1, 1'b1});
        do_start(2, 1'b0);
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        wait_done(10);

        // RUNindex now 7 (J=1): zero run with one remainder bit
        sb.push_back('{0, 1, 7, 0, 1'b1});
        do_start(100, 1'b0);
        send_bit(1'b0, 0); send_bit(1'b0, 0);
        wait_done(11);

        // Empty line: no bits consumed
        sb.push_back('{0, 0, 0, 0, 1'b0});
        do_start(0, 1'b0);
        wait_done(12);

        // Throttled stream with start/scan_start pulsed mid-run
        sb.push_back('{5, 1, 4, 0, 1'b1});
        do_start(100, 1'b1);
        send_bit(1'b1, 2); send_bit(1'b1, 2);
        dif.start          = 1'b1;
        dif.scan_start     = 1'b1;
        dif.line_remaining = 16'd7;
        tick(1);
        dif.start      = 1'b0;
        dif.scan_start = 1'b0;
        send_bit(1'b1, 1); send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b1, 2);
        wait_done(13);

        // Reset while in REMAINDER abandons the run
        do_start(100, 1'b1);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check("pre_reset_bit_ready", int'(dif.bit_ready), 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("mid_reset_busy", int'(dif.busy), 0);
        check("mid_reset_run_length", int'(dif.run_length), 0);
        check("mid_reset_interrupted", int'(dif.run_interrupted), 0);
        d0 = done_cnt;
        tick(10);
        check("no_done_after_reset", done_cnt, d0);

        // RUNindex back at 0: a lone 0 bit ends the run
        sb.push_back('{0, 1, 0, 0, 1'b1});
        do_start(100, 1'b0);
        send_bit(1'b0, 0);
        wait_done(d0 + 1);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
